// File: rtl/sweep_pkg.sv
// Shared types and helpers for the truth-table sweeper.
// Holds the FSM state type, the Gray encoder and the default MISR polynomial.
package sweep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        DONE
    } sweep_state_e;

    localparam int MAX_N_IN = 16;

    localparam logic [15:0] DEFAULT_POLY = 16'h1021;

    // Reflected binary code: consecutive inputs differ by exactly one output bit.
    function automatic logic [MAX_N_IN-1:0] gray_encode(input logic [MAX_N_IN-1:0] v);
        return v ^ (v >> 1);
    endfunction

endpackage

// File: rtl/sweep_misr.sv
// Multiple-input signature register that compacts sampled DUT responses.
// clr wins over en so a restart always begins from an all-zero signature.
module sweep_misr #(
    parameter int                N_OUT  = 2,
    parameter int                MISR_W = 16,
    parameter logic [MISR_W-1:0] POLY   = MISR_W'(16'h1021)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [N_OUT-1:0]  din,
    output logic [MISR_W-1:0] sig
);

    logic [MISR_W-1:0] feedback;
    logic [MISR_W-1:0] sig_next;

    // Shift left, fold the polynomial in when the MSB falls out, then mix in the response.
    always_comb begin
        feedback = sig[MISR_W-1] ? POLY : '0;
        sig_next = {sig[MISR_W-2:0], 1'b0} ^ feedback ^ MISR_W'(din);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig <= '0;
        end else if (clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus engine: walks all 2^N_IN input vectors, holds each for HOLD cycles
// and compacts the sampled responses into a MISR. Define GRAY_ORDER_EN for Gray-order stimulus.
module truth_table_sweeper
    import sweep_pkg::*;
#(
    parameter int                N_IN   = 3,
    parameter int                N_OUT  = 2,
    parameter int                HOLD   = 25,
    parameter int                MISR_W = 16,
    parameter logic [MISR_W-1:0] POLY   = MISR_W'(DEFAULT_POLY)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N_OUT-1:0]  resp,
    output logic [N_IN-1:0]   stim,
    output logic [N_IN-1:0]   vec_idx,
    output logic              sample,
    output logic              busy,
    output logic              done,
    output logic [MISR_W-1:0] signature
);

    localparam int                HOLD_W    = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [N_IN-1:0]   IDX_LAST  = '1;
    localparam logic [N_IN-1:0]   IDX_ONE   = N_IN'(1);
    localparam logic              HOLD_IS_1 = (HOLD == 1);

    sweep_state_e      state;
    logic [HOLD_W-1:0] hold_cnt;
    logic              start_acc;

    function automatic logic [N_IN-1:0] enc(input logic [N_IN-1:0] i);
`ifdef GRAY_ORDER_EN
        return N_IN'(gray_encode(MAX_N_IN'(i)));
`else
        return i;
`endif
    endfunction

    // A start is only honoured outside APPLY; it also clears the signature on the same edge.
    assign start_acc = start && (state != APPLY);

    // sample is registered one step ahead: it is set on the edge that loads the last hold count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
            vec_idx  <= '0;
            stim     <= '0;
            sample   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= APPLY;
                        hold_cnt <= '0;
                        vec_idx  <= '0;
                        stim     <= enc('0);
                        sample   <= HOLD_IS_1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                APPLY: begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= '0;
                        if (vec_idx == IDX_LAST) begin
                            state  <= DONE;
                            sample <= 1'b0;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                        end else begin
                            vec_idx <= vec_idx + IDX_ONE;
                            stim    <= enc(vec_idx + IDX_ONE);
                            sample  <= HOLD_IS_1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_ONE;
                        sample   <= ((hold_cnt + HOLD_ONE) == HOLD_LAST);
                    end
                end
                default: begin
                    state  <= IDLE;
                    sample <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                end
            endcase
        end
    end

    sweep_misr #(
        .N_OUT  (N_OUT),
        .MISR_W (MISR_W),
        .POLY   (POLY)
    ) u_misr (
        .clk (clk),
        .rst (rst),
        .clr (start_acc),
        .en  (sample),
        .din (resp),
        .sig (signature)
    );

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: cycle-level reference model plus literal checks,
// with a second small instance exercising HOLD=1 and a 4-bit MISR.
module tb_truth_table_sweeper;

    localparam int          N_IN   = 3;
    localparam int          N_OUT  = 2;
    localparam int          HOLD   = 4;
    localparam int          MISR_W = 16;
    localparam logic [15:0] POLY_M = 16'h1021;
    localparam int          NVEC   = 1 << N_IN;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [N_OUT-1:0]  resp;
    logic [N_IN-1:0]   stim;
    logic [N_IN-1:0]   vec_idx;
    logic              sample;
    logic              busy;
    logic              done;
    logic [MISR_W-1:0] signature;

    logic              start2;
    logic              resp2 = 1'b1;
    logic [2:0]        stim2;
    logic [2:0]        vec_idx2;
    logic              sample2;
    logic              busy2;
    logic              done2;
    logic [3:0]        signature2;

    int checks   = 0;
    int failures = 0;

    int               resp_mode = 0;
    logic [N_OUT-1:0] rand_resp = '0;
    bit               cmp_en    = 1'b0;

    int busy_cnt, sample_cnt, busy2_cnt, sample2_cnt;
    int seq_q[$];
    int seq2_q[$];
    int exp_seq[8];

    int                m_t;
    int                m_idx;
    bit                m_busy;
    bit                m_done;
    logic [MISR_W-1:0] m_sig;

    always #5 clk = ~clk;

    truth_table_sweeper #(
        .N_IN   (N_IN),
        .N_OUT  (N_OUT),
        .HOLD   (HOLD),
        .MISR_W (MISR_W),
        .POLY   (POLY_M)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .resp      (resp),
        .stim      (stim),
        .vec_idx   (vec_idx),
        .sample    (sample),
        .busy      (busy),
        .done      (done),
        .signature (signature)
    );

    truth_table_sweeper #(
        .N_IN   (3),
        .N_OUT  (1),
        .HOLD   (1),
        .MISR_W (4),
        .POLY   (4'h3)
    ) dut_sig (
        .clk       (clk),
        .rst       (rst),
        .start     (start2),
        .resp      (resp2),
        .stim      (stim2),
        .vec_idx   (vec_idx2),
        .sample    (sample2),
        .busy      (busy2),
        .done      (done2),
        .signature (signature2)
    );

    function automatic logic [N_IN-1:0] enc_m(input int i);
`ifdef GRAY_ORDER_EN
        return N_IN'(i ^ (i >> 1));
`else
        return N_IN'(i);
`endif
    endfunction

    function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] s, input logic [N_OUT-1:0] r);
        int v;
        v = int'(s) * 2;
        if (v >= 65536) v = (v - 65536) ^ int'(POLY_M);
        return MISR_W'(v) ^ MISR_W'(r);
    endfunction

    // Stand-in combinational block under test
    function automatic logic [1:0] comb_dut(input logic [2:0] s);
        return {s[0] ^ s[2], s[1] & s[0]};
    endfunction

    always_comb begin
        case (resp_mode)
            0:       resp = '0;
            1:       resp = comb_dut(stim);
            default: resp = rand_resp;
        endcase
    end

    always @(posedge clk) begin
        #1 rand_resp = N_OUT'($urandom);
    end

    // Reference: position m_t counts cycles since the start edge; vector = m_t / HOLD.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_t = 0; m_idx = 0; m_busy = 0; m_done = 0; m_sig = '0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy = 1; m_done = 0; m_t = 0; m_idx = 0; m_sig = '0;
            end
        end else begin
            if (m_t % HOLD == HOLD - 1) m_sig = misr_step(m_sig, resp);
            if (m_t == NVEC * HOLD - 1) begin
                m_busy = 0;
                m_done = 1;
            end else begin
                m_t++;
                m_idx = m_t / HOLD;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s: timed out at %0t", name, $time);
    endtask

    always @(negedge clk) begin
        if (!rst && cmp_en) begin
            check("stim", 32'(stim), 32'(enc_m(m_idx)));
            check("vec_idx", 32'(vec_idx), 32'(m_idx));
            check("sample", 32'(sample), 32'(m_busy && (m_t % HOLD == HOLD - 1)));
            check("busy", 32'(busy), 32'(m_busy));
            check("done", 32'(done), 32'(m_done));
            check("signature", 32'(signature), 32'(m_sig));
            if (busy) busy_cnt++;
            if (sample) begin
                sample_cnt++;
                seq_q.push_back(int'(stim));
            end
            if (busy2) begin
                busy2_cnt++;
                seq2_q.push_back(int'(stim2));
            end
            if (sample2) sample2_cnt++;
        end
    end

    task automatic clear_counts();
        busy_cnt = 0; sample_cnt = 0; busy2_cnt = 0; sample2_cnt = 0;
        seq_q.delete();
        seq2_q.delete();
    endtask

    task automatic applyStimulus(input bit both);
        @(posedge clk); #1;
        start = 1'b1;
        start2 = both;
        @(posedge clk); #1;
        start = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (!done) timeout_fail(name);
    endtask

    task automatic wait_vec(input int v, input string name);
        int n = 0;
        while (!(busy && int'(vec_idx) == v) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (!(busy && int'(vec_idx) == v)) timeout_fail(name);
    endtask

    task automatic checkOutput(input string name, input logic [MISR_W-1:0] exp_sig);
        check({name, "_sig"}, 32'(signature), 32'(exp_sig));
        check({name, "_vec"}, 32'(vec_idx), 32'(NVEC - 1));
        check({name, "_stim"}, 32'(stim), 32'(exp_seq[7]));
    endtask

    logic [MISR_W-1:0] exp_comb_sig;

    initial begin
`ifdef GRAY_ORDER_EN
        exp_seq = '{0, 1, 3, 2, 6, 7, 5, 4};
`else
        exp_seq = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif
        exp_comb_sig = '0;
        for (int i = 0; i < NVEC; i++) exp_comb_sig = misr_step(exp_comb_sig, comb_dut(enc_m(i)));

        rst = 1'b1; start = 1'b0; start2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_stim", 32'(stim), 0);
        check("rst_vec", 32'(vec_idx), 0);
        check("rst_sample", 32'(sample), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_sig", 32'(signature), 0);
        rst = 1'b0;
        cmp_en = 1'b1;

        // Zero response sweep on both instances
        resp_mode = 0;
        clear_counts();
        applyStimulus(1'b1);
        wait_done("sweep_zero");
        @(negedge clk);
        check("zero_busy_cycles", 32'(busy_cnt), 32);
        check("zero_samples", 32'(sample_cnt), 8);
        checkOutput("zero", 16'h0000);
        for (int i = 0; i < 8; i++)
            check($sformatf("seq[%0d]", i), 32'(i < seq_q.size() ? seq_q[i] : -1), 32'(exp_seq[i]));
        check("h1_busy_cycles", 32'(busy2_cnt), 8);
        check("h1_samples", 32'(sample2_cnt), 8);
        check("h1_sig", 32'(signature2), 32'h0000000D);
        check("h1_done", 32'(done2), 1);
        check("h1_stim_last", 32'(stim2), 32'(exp_seq[7]));
        for (int i = 0; i < 8; i++)
            check($sformatf("h1_seq[%0d]", i), 32'(i < seq2_q.size() ? seq2_q[i] : -1), 32'(exp_seq[i]));
        repeat (3) @(posedge clk);
        #1;
        check("hold_after_done_stim", 32'(stim), 32'(exp_seq[7]));
        check("hold_after_done", 32'(done), 1);

        // Undisturbed sweep with a deterministic response
        resp_mode = 1;
        applyStimulus(1'b0);
        wait_done("sweep_comb");
        checkOutput("comb", exp_comb_sig);

        // Restart request mid-sweep is ignored
        applyStimulus(1'b0);
        wait_vec(3, "wait_vec3");
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("sweep_ignored_start");
        checkOutput("ign", exp_comb_sig);

        // Asynchronous reset mid-sweep, checked before any clock edge
        applyStimulus(1'b0);
        wait_vec(5, "wait_vec5");
        #1 rst = 1'b1;
        #1;
        check("arst_stim", 32'(stim), 0);
        check("arst_vec", 32'(vec_idx), 0);
        check("arst_sample", 32'(sample), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_done", 32'(done), 0);
        check("arst_sig", 32'(signature), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        applyStimulus(1'b0);
        wait_done("sweep_after_rst");
        checkOutput("post_rst", exp_comb_sig);

        // Random responses with stray start pulses during the sweep
        resp_mode = 2;
        for (int s = 0; s < 3; s++) begin
            int n = 0;
            applyStimulus(1'b0);
            while (!done && n < 300) begin
                start = (int'(vec_idx) < NVEC - 2) && ($urandom_range(0, 7) == 0);
                @(posedge clk); #1;
                n++;
            end
            start = 1'b0;
            if (!done) timeout_fail("sweep_random");
            check("rand_done_sig", 32'(signature), 32'(m_sig));
        end

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Synthesizable, parametrised exhaustive stimulus engine for small combinational blocks. It drives every input combination of an N_IN-bit DUT in turn and holds each vector for a fixed settle time. At the end of each hold it samples the DUT's outputs and compacts them into a MISR signature. The block replaces hand-written stimulus sequences in bring-up and self-test wrappers around combinational sub-circuits.

## Interface
Parameters:
- N_IN, 3: DUT input width; the block sweeps 2^N_IN vectors. Legal range 1..16.
- N_OUT, 2: DUT output width. Must satisfy N_OUT <= MISR_W.
- HOLD, 25: clock cycles each vector is held. Must be >= 1.
- MISR_W, 16: signature width.
- POLY, 16'h1021: MISR feedback polynomial, MISR_W bits wide.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a sweep; one-cycle pulse or level
- resp  in  N_OUT  DUT outputs
- stim  out  N_IN  DUT inputs
- vec_idx  out  N_IN  ordinal of the current vector
- sample  out  1  high on the cycle in which resp is captured
- busy  out  1  sweep in progress
- done  out  1  sweep complete; signature valid
- signature  out  MISR_W  compacted response

## Operation
- States: IDLE, APPLY, DONE.
- IDLE:
  - start=1 -> APPLY. On the same edge: vec_idx=0, stim=enc(0), hold counter=0, signature cleared to 0.
- APPLY:
  - busy=1. The hold counter runs 0..HOLD-1.
  - sample=1 while the hold counter equals HOLD-1.
  - On that edge, signature is updated: sig_next = (sig<<1) ^ (sig[MISR_W-1] ? POLY : 0) ^ zero-extended resp.
  - If vec_idx < 2^N_IN-1: vec_idx increments, stim=enc(vec_idx+1), hold counter=0.
  - Otherwise: -> DONE.
- DONE:
  - done=1, busy=0.
  - stim and vec_idx hold the last vector; signature is frozen.
  - start=1 -> restart exactly as from IDLE.
- start while in APPLY is ignored.
- enc() is the identity unless the Gray-order feature is compiled in (see Configuration).
- vec_idx wraps only by completion; there is no modular wrap during a sweep.

## Timing
- Reset values: stim=0, vec_idx=0, sample=0, busy=0, done=0, signature=0, state=IDLE.
- Reset takes effect immediately and asynchronously, mid-sweep included. The sweep is abandoned with no partial done.
- Start latency: start sampled high at edge k -> busy=1 and stim=enc(0) from edge k onward.
- Each vector is presented for exactly HOLD cycles. sample occurs on the last cycle of each hold.
- Total busy duration is 2^N_IN * HOLD cycles. done rises on the edge that ends the last hold cycle.
- HOLD=1: sample is high on every busy cycle, and stim changes every cycle.
- resp must be stable at the sampling edge; the block adds no synchronizer.

## Configuration
- GRAY_ORDER_EN:
  - Defined: enc(i) = i ^ (i>>1), so stim changes by exactly one bit between consecutive vectors. vec_idx still counts 0..2^N_IN-1.
  - Undefined: enc(i) = i (binary order).
- The signature depends on vector order, so expected signatures differ between the two builds.

## Structure
- Package sweep_pkg:
  - state typedef (IDLE/APPLY/DONE);
  - gray-encode function;
  - default POLY constant.
- Sub-module sweep_misr (parameters MISR_W, N_OUT, POLY):
  - ports clk, rst, clr, en, din[N_OUT], sig[MISR_W].
  - Driven with clr on start and en on sample.
- The top level holds the FSM, hold counter, vector counter and encoder.

## Test plan
- Reset state: N_IN=3, HOLD=4, resp=0 -> start -> busy high for 32 cycles, sample pulses 8 times, then done=1 and signature=0.
- Binary order: default build, N_IN=3 -> stim sequence 0,1,2,3,4,5,6,7 with each value held HOLD cycles; stim=7 held after done.
- Signature: MISR_W=4, POLY=4'h3, N_OUT=1, resp=1 constant -> signature=4'hD after done.
- Gray order: GRAY_ORDER_EN defined, N_IN=3 -> stim sequence 0,1,3,2,6,7,5,4 while vec_idx runs 0..7.
- Start during sweep: start pulsed while busy and vec_idx=3 -> no effect; sweep completes with the same signature as an undisturbed run.
- Mid-sweep reset: rst asserted at vec_idx=5 -> all outputs return to reset values with no clock edge needed. A new start then yields a full, correct sweep.
